leaf_stream_egress_buffer: RTL and testbench

Buffers packets from a leaf interface's flow-control stage (its `stream_out` bus) before they enter the BFT switch port. Presents them to the switch through a valid/ready handshake. When the buffer cannot take a packet, the block drops it and pulses `resend` back to the flow-control stage, which retransmits. Drop and occupancy statistics are kept for done-mode reporting.

---
 rtl/leaf_pkt_pkg.sv | 33 +++
 rtl/leaf_stream_egress_buffer_if.sv | 29 ++
 rtl/leaf_egress_fifo_mem.sv | 23 ++
 rtl/leaf_stream_egress_buffer.sv | 112 +++++++++++
 tb/tb_leaf_stream_egress_buffer.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/leaf_pkt_pkg.sv
// Shared leaf packet layout and helpers used by the leaf egress and
// statistics blocks.
package leaf_pkt_pkg;

  localparam int PACKET_BITS_DEF   = 97;
  localparam int NUM_LEAF_BITS_DEF = 6;

  localparam int VLD_BIT  = PACKET_BITS_DEF - 1;
  localparam int LEAF_MSB = PACKET_BITS_DEF - 2;
  localparam int PORT_MSB = LEAF_MSB - NUM_LEAF_BITS_DEF;

  // Helpers take widest-case operands; callers zero-extend into them.
  localparam int PKT_MAX_BITS = 256;
  localparam int CNT_MAX_BITS = 32;

  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_RD   = 2'b01,
    FIFO_WR   = 2'b10,
    FIFO_RDWR = 2'b11
  } fifo_op_e;

  function automatic logic pkt_valid(input logic [PKT_MAX_BITS-1:0] p,
                                     input logic [7:0] vld_bit = 8'(VLD_BIT));
    return p[vld_bit];
  endfunction

  function automatic logic [CNT_MAX_BITS-1:0] sat_inc(input logic [CNT_MAX_BITS-1:0] v,
                                                      input logic [CNT_MAX_BITS-1:0] max_val);
    return (v >= max_val) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/leaf_stream_egress_buffer_if.sv
// Egress buffer bus: flow-control input stream, switch-side handshake and
// statistics readout.
interface leaf_stream_egress_buffer_if #(
  parameter int PACKET_BITS = 97,
  parameter int DEPTH_BITS  = 3,
  parameter int CNT_BITS    = 16
) ();

  logic [PACKET_BITS-1:0] stream_in;
  logic                   resend;
  logic [PACKET_BITS-1:0] packet_out;
  logic                   out_vld;
  logic                   out_rdy;
  logic [DEPTH_BITS:0]    occupancy;
  logic [CNT_BITS-1:0]    drop_cnt;
  logic [CNT_BITS-1:0]    sent_cnt;

  // master: flow-control stage plus switch port; slave: the egress buffer
  modport master (
    output stream_in, out_rdy,
    input  resend, packet_out, out_vld, occupancy, drop_cnt, sent_cnt
  );

  modport slave (
    input  stream_in, out_rdy,
    output resend, packet_out, out_vld, occupancy, drop_cnt, sent_cnt
  );

endinterface

// File: rtl/leaf_egress_fifo_mem.sv
// Packet storage for the egress FIFO: synchronous write, asynchronous read,
// intended to map onto distributed RAM.
module leaf_egress_fifo_mem #(
  parameter int WIDTH     = 97,
  parameter int ADDR_BITS = 3
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/leaf_stream_egress_buffer.sv
// Leaf egress buffer: queues flow-control packets for the BFT switch port,
// drops with a resend pulse when full, and keeps drop/sent statistics.
module leaf_stream_egress_buffer
  import leaf_pkt_pkg::*;
#(
  parameter int PACKET_BITS   = 97,
  parameter int NUM_LEAF_BITS = 6,
  parameter int DEPTH_BITS    = 3,
  parameter int CNT_BITS      = 16
) (
  input logic                     clk,
  input logic                     reset,
  leaf_stream_egress_buffer_if.slave bus
);

  localparam int DEPTH = 2**DEPTH_BITS;
  localparam logic [DEPTH_BITS:0]       FULL_LEVEL = (DEPTH_BITS+1)'(DEPTH);
  localparam logic [DEPTH_BITS:0]       OCC_ONE    = (DEPTH_BITS+1)'(1);
  localparam logic [DEPTH_BITS-1:0]     PTR_ONE    = DEPTH_BITS'(1);
  localparam logic [CNT_MAX_BITS-1:0]   CNT_MAX    = CNT_MAX_BITS'((64'd1 << CNT_BITS) - 64'd1);

  if (PACKET_BITS > PKT_MAX_BITS || CNT_BITS > CNT_MAX_BITS ||
      NUM_LEAF_BITS < 1 || NUM_LEAF_BITS > PACKET_BITS - 2) begin : g_bad_params
    $error("leaf_stream_egress_buffer: unsupported parameter combination");
  end

  if (PACKET_BITS == VLD_BIT + 1 && NUM_LEAF_BITS == NUM_LEAF_BITS_DEF) begin : g_default_layout
    if (LEAF_MSB != PACKET_BITS - 2 || PORT_MSB != LEAF_MSB - NUM_LEAF_BITS) begin : g_bad_layout
      $error("leaf_stream_egress_buffer: packet field layout mismatch");
    end
  end

  logic [PKT_MAX_BITS-1:0] stream_ext;
  logic                    in_vld;
  logic                    full;
  logic                    empty;
  logic                    wr;
  logic                    rd;
  logic                    drop;
  fifo_op_e                op;

  logic [DEPTH_BITS-1:0]   wr_ptr;
  logic [DEPTH_BITS-1:0]   rd_ptr;
  logic [DEPTH_BITS:0]     occ;
  logic [DEPTH_BITS:0]     occ_nxt;
  logic                    resend_p1;
  logic [CNT_BITS-1:0]     drop_cnt_r;
  logic [CNT_BITS-1:0]     sent_cnt_r;
  logic [PACKET_BITS-1:0]  head;

  assign stream_ext = PKT_MAX_BITS'(bus.stream_in);
  assign in_vld     = pkt_valid(stream_ext, 8'(PACKET_BITS-1));

  // full/empty come only from registered occupancy, so a same-cycle read
  // never frees room for a write (no bypass, no out_rdy -> full path).
  assign full  = (occ == FULL_LEVEL);
  assign empty = (occ == '0);
  assign wr    = in_vld & ~full;
  assign drop  = in_vld & full;
  assign rd    = ~empty & bus.out_rdy;

  always_comb begin
    op      = fifo_op_e'({wr, rd});
    occ_nxt = occ;
    case (op)
      FIFO_WR:   occ_nxt = occ + OCC_ONE;
      FIFO_RD:   occ_nxt = occ - OCC_ONE;
      FIFO_IDLE,
      FIFO_RDWR: occ_nxt = occ;
      default:   occ_nxt = occ;
    endcase
  end

  // ---- stage p1: pointers, occupancy, resend pulse and statistics ----
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      resend_p1  <= 1'b0;
      drop_cnt_r <= '0;
      sent_cnt_r <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd) rd_ptr <= rd_ptr + PTR_ONE;
      occ       <= occ_nxt;
      resend_p1 <= drop;
      if (drop) drop_cnt_r <= CNT_BITS'(sat_inc(CNT_MAX_BITS'(drop_cnt_r), CNT_MAX));
      if (rd)   sent_cnt_r <= CNT_BITS'(sat_inc(CNT_MAX_BITS'(sent_cnt_r), CNT_MAX));
    end
  end

  leaf_egress_fifo_mem #(
    .WIDTH     (PACKET_BITS),
    .ADDR_BITS (DEPTH_BITS)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr),
    .wr_addr (wr_ptr),
    .wr_data (bus.stream_in),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  assign bus.out_vld    = ~empty;
  assign bus.packet_out = empty ? '0 : {1'b1, head[PACKET_BITS-2:0]};
  assign bus.resend     = resend_p1;
  assign bus.occupancy  = occ;
  assign bus.drop_cnt   = drop_cnt_r;
  assign bus.sent_cnt   = sent_cnt_r;

endmodule

// File: tb/tb_leaf_stream_egress_buffer.sv
// Scoreboard bench for leaf_stream_egress_buffer: a queue-level model predicts
// accepted packets, drops and counters; a monitor checks every cycle.
module tb_leaf_stream_egress_buffer;

  localparam int PB      = 97;
  localparam int DB      = 3;
  localparam int CB      = 4;
  localparam int DEPTH   = 8;
  localparam int CNT_MAX = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;

  leaf_stream_egress_buffer_if #(.PACKET_BITS(PB), .DEPTH_BITS(DB), .CNT_BITS(CB)) bus ();

  leaf_stream_egress_buffer #(
    .PACKET_BITS   (PB),
    .NUM_LEAF_BITS (6),
    .DEPTH_BITS    (DB),
    .CNT_BITS      (CB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [PB-1:0] exp_q [$];
  int            mocc;
  int            drop_m;
  int            sent_m;
  logic          resend_m;
  bit            mon_en;
  int            n_tests;
  int            n_fail;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [PB-2:0] rnd_payload();
    return {$urandom, $urandom, $urandom};
  endfunction

  // Monitor: compare DUT against the model; pop the scoreboard on each handoff.
  initial begin
    logic [PB-1:0] exp_pkt;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("out_vld",   128'(bus.out_vld),   128'(mocc != 0));
        check("occupancy", 128'(bus.occupancy), 128'(mocc));
        check("resend",    128'(bus.resend),    128'(resend_m));
        check("drop_cnt",  128'(bus.drop_cnt),  128'(drop_m));
        check("sent_cnt",  128'(bus.sent_cnt),  128'(sent_m));
        if (bus.out_vld && bus.out_rdy) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL packet_out: DUT presented %0h with nothing expected", bus.packet_out);
          end else begin
            exp_pkt = exp_q.pop_front();
            check("packet_out", 128'(bus.packet_out), 128'(exp_pkt));
          end
        end
      end
    end
  end

  // One clock of stimulus; the model applies the buffer rules at the edge.
  task automatic step(input logic v, input logic [PB-2:0] d, input logic rdy);
    bit full, wr, rd, drop;
    bus.stream_in = {v, d};
    bus.out_rdy   = rdy;
    @(posedge clk);
    full = (mocc == DEPTH);
    wr   = v && !full;
    drop = v && full;
    rd   = (mocc != 0) && rdy;
    if (wr) exp_q.push_back({1'b1, d});
    if (drop && drop_m < CNT_MAX) drop_m++;
    if (rd && sent_m < CNT_MAX) sent_m++;
    resend_m = drop;
    mocc = mocc + int'(wr) - int'(rd);
    #1;
  endtask

  task automatic do_reset(input logic v, input logic rdy);
    bus.stream_in = {v, rnd_payload()};
    bus.out_rdy   = rdy;
    reset = 1'b1;
    @(posedge clk);
    exp_q.delete();
    mocc = 0;
    drop_m = 0;
    sent_m = 0;
    resend_m = 1'b0;
    #1;
    reset = 1'b0;
    bus.stream_in = '0;
    bus.out_rdy = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic drain();
    for (int k = 0; k < 64 && mocc != 0; k++) step(1'b0, '0, 1'b1);
    check("drain_out_vld", 128'(bus.out_vld), 128'(0));
    check("drain_scoreboard", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    mon_en = 1'b0;
    mocc = 0;
    drop_m = 0;
    sent_m = 0;
    resend_m = 1'b0;
    bus.stream_in = '0;
    bus.out_rdy = 1'b0;

    // Single packet
    do_reset(1'b0, 1'b0);
    check("rst_out_vld", 128'(bus.out_vld), 128'(0));
    check("rst_packet_out", 128'(bus.packet_out), 128'(0));
    step(1'b1, 96'hA5, 1'b1);
    check("single_vld_rise", 128'(bus.out_vld), 128'(1));
    check("single_pkt", 128'(bus.packet_out), {31'd0, 1'b1, 96'hA5});
    step(1'b0, '0, 1'b1);
    check("single_vld_fall", 128'(bus.out_vld), 128'(0));
    check("single_sent", 128'(bus.sent_cnt), 128'(1));
    step(1'b0, '0, 1'b1);
    check("single_no_resend", 128'(bus.resend), 128'(0));

    // Fill and overflow
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, rnd_payload(), 1'b0);
      if (i == 7) check("fill_no_resend_pkt8", 128'(bus.resend), 128'(0));
      if (i >= 8) check("fill_resend_pulse", 128'(bus.resend), 128'(1));
    end
    check("fill_occ", 128'(bus.occupancy), 128'(8));
    check("fill_drop", 128'(bus.drop_cnt), 128'(2));
    step(1'b0, '0, 1'b0);
    check("fill_resend_end", 128'(bus.resend), 128'(0));
    drain();

    // Full with read but no bypass
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, rnd_payload(), 1'b0);
    step(1'b1, rnd_payload(), 1'b1);
    check("nobypass_resend", 128'(bus.resend), 128'(1));
    check("nobypass_occ", 128'(bus.occupancy), 128'(7));
    check("nobypass_drop", 128'(bus.drop_cnt), 128'(1));
    drain();

    // Wrap-around
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(i % 2 == 0, rnd_payload(), i % 2 == 1);
    check("wrap_no_drop", 128'(bus.drop_cnt), 128'(0));
    drain();

    // Invalid input and reset
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, rnd_payload(), 1'b0);
    step(1'b0, rnd_payload(), 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, rnd_payload(), 1'b0);
    check("invalid_sent", 128'(bus.sent_cnt), 128'(1));
    check("invalid_drop", 128'(bus.drop_cnt), 128'(0));
    check("invalid_occ", 128'(bus.occupancy), 128'(2));
    for (int i = 0; i < 3; i++) step(1'b1, rnd_payload(), 1'b0);
    check("prereset_occ", 128'(bus.occupancy), 128'(5));
    do_reset(1'b1, 1'b1);
    check("midrst_vld", 128'(bus.out_vld), 128'(0));
    check("midrst_occ", 128'(bus.occupancy), 128'(0));
    check("midrst_drop", 128'(bus.drop_cnt), 128'(0));
    check("midrst_sent", 128'(bus.sent_cnt), 128'(0));
    check("midrst_resend", 128'(bus.resend), 128'(0));
    step(1'b0, '0, 1'b1);
    check("postrst_resend", 128'(bus.resend), 128'(0));

    // Saturation
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, rnd_payload(), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, rnd_payload(), 1'b0);
    check("sat_drop", 128'(bus.drop_cnt), 128'(15));
    drain();

    // Random traffic
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, rnd_payload(), 1'($urandom_range(0, 1)));
    drain();

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
